unidade_busca: RTL
==================

# unidade_busca

Instruction fetch stage of the monocycle RV32I core, directly upstream of `unidade_controle`. It owns the PC, issues word requests to instruction memory through a req/ready handshake, and buffers in-order responses in a small FIFO. It presents one instruction per cycle to decode as opcode/funct3/funct7 fields plus the full word and its PC. Redirects from branch/jump resolution flush the FIFO and discard stale in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000: PC fetched first after reset; bits [1:0] must be 0.
- `DEPTH`, 4: FIFO entries and max outstanding+buffered words; power of two, 2..8.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `imem_req` output 1: fetch request valid.
- `imem_addr` output 32: word address of request, [1:0]=00.
- `imem_ready` input 1: memory accepts request this cycle.
- `imem_rvalid` input 1: response word valid, in request order, ≥1 cycle after acceptance.
- `imem_rdata` input 32: response instruction word.
- `redirect_valid` input 1: one-cycle pulse, taken branch/JAL target.
- `redirect_pc` input 32: new PC; bits [1:0] ignored (forced 00).
- `inst_valid` output 1: head instruction valid for decode.
- `inst_ready` input 1: decode/execute consumes head this cycle.
- `inst` output 32: head instruction word.
- `inst_pc` output 32: PC of head instruction.
- `opcode` output 7: `inst[6:0]`.
- `funct3` output 3: `inst[14:12]`.
- `funct7` output 7: `inst[31:25]`.
- `err_resp` output 1: sticky, set by `imem_rvalid` with zero outstanding.

## Operation
- State: `fetch_pc`, `resp_pc`, outstanding count `oc` (0..DEPTH), FIFO count `bc` (0..DEPTH), FSM {BOOT, RUN, DRAIN}.
- Reset: state BOOT, `fetch_pc`=`resp_pc`=RESET_PC, `oc`=`bc`=0, `imem_req`=0, `imem_addr`=RESET_PC, `inst_valid`=0, `err_resp`=0; with `inst_valid`=0, `inst`=32'h0000_0013 (NOP), `inst_pc`=0, fields derived from `inst`.
- BOOT: one cycle, no request; unconditionally to RUN.
- RUN issue: `imem_req`=1 iff no `redirect_valid` and (`oc`+`bc` < DEPTH, or `oc`+`bc`==DEPTH and FIFO pop this cycle). `imem_addr`=`fetch_pc`. On req&ready: `oc`+1, `fetch_pc`+4 (mod 2^32 wrap). Addr held stable while req&!ready.
- RUN response: `imem_rvalid` pushes {`imem_rdata`, `resp_pc`} into FIFO; `oc`-1, `resp_pc`+4.
- Pop: `inst_valid`=(`bc`!=0 and state RUN); on `inst_valid`&`inst_ready`, `bc`-1. Push and pop same cycle: `bc` unchanged.
- Redirect (any state except BOOT, where it still loads PCs): FIFO cleared (`bc`=0, pending pop ignored), `fetch_pc`=`resp_pc`={redirect_pc[31:2],2'b00}; response arriving that cycle is discarded. Remaining `oc` (after that discard) >0 → DRAIN, else RUN.
- DRAIN: `imem_req`=0, `inst_valid`=0; each `imem_rvalid` discarded, `oc`-1; when `oc` reaches 0 (including this cycle's response) → RUN next cycle. Redirect in DRAIN: reload PCs, stay in DRAIN.
- `imem_rvalid` with `oc`==0: ignored, `err_resp`←1 until reset.
- Invariant `oc`+`bc` ≤ DEPTH; overflow impossible by issue rule.

## Timing
- Request accepted cycle N, response cycle N+1 earliest → `inst_valid` cycle N+2 (registered FIFO, no bypass).
- Sustained 1 instr/cycle with 1-cycle memory and DEPTH≥2 given `inst_ready` held high.
- Redirect cycle R with `oc`=0: new request issued R+1, first instruction valid R+3 with 1-cycle memory.
- `imem_req` depends combinationally on `inst_ready` and `redirect_valid`; all other outputs registered.
- `rst_n` assertion mid-transfer: immediate return to reset values; late responses after release with `oc`=0 set `err_resp` (memory must be reset together).

## Test plan
- Reset release, 1-cycle memory, `inst_ready`=1, program 0x00500093,0x00A00113,… → addrs 0,4,8… on consecutive cycles; first `inst_valid` cycle 3 after release, `opcode`=0010011, `inst_pc`=0; then one instr/cycle.
- `inst_ready`=0 for 10 cycles → exactly DEPTH=4 words accepted, `imem_req` low afterwards, FIFO order/PCs preserved on release.
- Memory latency 3, `redirect_valid` with `redirect_pc`=0x103 while `oc`=2 → DRAIN, two stale responses dropped, next `imem_addr`=0x100, first `inst_pc`=0x100.
- Redirect same cycle as `imem_rvalid` and pop → response discarded, `bc`=0, no `inst_valid` next cycle, no `imem_req` that cycle.
- `imem_ready` low 5 cycles with req high → `imem_addr` stable, `fetch_pc` unchanged; `fetch_pc`=0xFFFF_FFFC accepted → wraps to 0.
- Spurious `imem_rvalid` with `oc`=0 → `err_resp`=1 held; `rst_n` low mid-burst → all outputs to reset values asynchronously.

Source files
------------

// File: rtl/unidade_busca_if.sv
// unidade_busca_if: fetch-stage bundle of instruction-memory, redirect and decode handshakes
interface unidade_busca_if;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_ready;
  logic imem_rvalid;
  logic [31:0] imem_rdata;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic inst_valid;
  logic inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic err_resp;
  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, opcode, funct3, funct7, err_resp,
    input imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
  modport slave (
    input imem_req, imem_addr, inst_valid, inst, inst_pc, opcode, funct3, funct7, err_resp,
    output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/unidade_busca.sv
// unidade_busca: RV32I fetch stage owning the PC, issuing word fetches and buffering in-order responses
module unidade_busca #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  unidade_busca_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] FULL = (CW + 1)'(DEPTH);
  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;
  state_t state;
  logic [31:0] fetch_pc, resp_pc, tgt;
  logic [CW-1:0] oc, bc, oc_n;
  logic [CW:0] tot;
  logic [AW-1:0] rd, wr;
  logic [31:0] fifo_inst [DEPTH];
  logic [31:0] fifo_pc [DEPTH];
  logic err, pop, acc, rsp, push;
  assign tgt = bus.redirect_pc & 32'hFFFF_FFFC;
  assign bus.imem_addr = fetch_pc;
  assign bus.inst_valid = state == RUN && bc != '0;
  assign bus.inst = bus.inst_valid ? fifo_inst[rd] : 32'h0000_0013;
  assign bus.inst_pc = bus.inst_valid ? fifo_pc[rd] : 32'h0;
  assign bus.opcode = bus.inst[6:0];
  assign bus.funct3 = bus.inst[14:12];
  assign bus.funct7 = bus.inst[31:25];
  assign bus.err_resp = err;
  // issue rule: refill a slot the moment decode frees one, never during a redirect
  always_comb begin
    tot = {1'b0, oc} + {1'b0, bc};
    pop = bus.inst_valid & bus.inst_ready;
    bus.imem_req = state == RUN && !bus.redirect_valid && (tot < FULL || (tot == FULL && pop));
    acc = bus.imem_req & bus.imem_ready;
    rsp = bus.imem_rvalid && oc != '0;
    push = rsp && state == RUN && !bus.redirect_valid;
    oc_n = oc + CW'(acc) - CW'(rsp);
  end
  // response storage; stale or spurious words never reach it
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr] <= bus.imem_rdata;
      fifo_pc[wr] <= resp_pc;
    end
  end
  // control FSM: PCs, outstanding/buffered counts, FIFO pointers and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      oc <= '0;
      bc <= '0;
      rd <= '0;
      wr <= '0;
      err <= 1'b0;
    end else begin
      err <= err | (bus.imem_rvalid && oc == '0);
      oc <= oc_n;
      if (bus.redirect_valid) begin
        fetch_pc <= tgt;
        resp_pc <= tgt;
        bc <= '0;
        rd <= '0;
        wr <= '0;
        state <= (state == BOOT || oc_n == '0) ? RUN : DRAIN;
      end else begin
        if (acc) fetch_pc <= fetch_pc + 32'd4;
        if (push) resp_pc <= resp_pc + 32'd4;
        if (push) wr <= wr + AW'(1);
        if (pop) rd <= rd + AW'(1);
        bc <= bc + CW'(push) - CW'(pop);
        state <= (state == BOOT || (state == DRAIN && oc_n == '0)) ? RUN : state;
      end
    end
  end
endmodule
